psdram_arbiter: RTL and testbench

- Sequences all asynchronous-mode PSDRAM accesses for two requesters: the VGA frame reader and the UART-data writer.
- Replaces the button-toggled combinational PSDRAM mux, so both masters share the memory concurrently.
- Sits between the requesters and the board pins. The top level keeps only the MemDB tristate (MemDB = mem_dout_en ? mem_dout : 16'bz; mem_din = MemDB).

---
 rtl/psdram_arbiter.sv | 154 +++++++++++++++
 tb/tb_psdram_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/psdram_arbiter.sv
// Arbitrates VGA reads and UART-data writes onto an asynchronous-mode PSDRAM.
// Every memory-side output comes from a register; a write can only take the bus from pending reads after STARVE_LIMIT consecutive reads.
module psdram_arbiter #(
  parameter int ADDR_W          = 23,
  parameter int ACCESS_CYCLES   = 4,
  parameter int RECOVERY_CYCLES = 1,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [15:0]       vga_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_ack,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamCE,
  output logic              RamLB,
  output logic              RamUB,
  output logic [ADDR_W-1:0] MemAdr,
  output logic [15:0]       mem_dout,
  output logic              mem_dout_en,
  input  logic [15:0]       mem_din,
  output logic              RamADV,
  output logic              RamCRE,
  output logic              RamClk
);
  localparam int CW = $clog2(ACCESS_CYCLES + RECOVERY_CYCLES + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RECOVER} state_t;

  typedef struct packed {
    logic              oe;
    logic              we;
    logic              ce;
    logic              lb;
    logic              ub;
    logic              dout_en;
    logic [ADDR_W-1:0] adr;
    logic [15:0]       dout;
  } pins_t;

  localparam pins_t PINS_RST = '{oe: 1'b1, we: 1'b1, ce: 1'b1, lb: 1'b1, ub: 1'b1,
                                 dout_en: 1'b0, adr: '0, dout: '0};

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SW-1:0] starve, starve_nxt;
  pins_t         pins, pins_nxt;
  logic          vga_ack_nxt, wr_ack_nxt;
  logic [15:0]   vga_rdata_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      starve    <= '0;
      pins      <= PINS_RST;
      vga_ack   <= 1'b0;
      wr_ack    <= 1'b0;
      vga_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      starve    <= starve_nxt;
      pins      <= pins_nxt;
      vga_ack   <= vga_ack_nxt;
      wr_ack    <= wr_ack_nxt;
      vga_rdata <= vga_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    starve_nxt    = starve;
    pins_nxt      = pins;
    vga_ack_nxt   = 1'b0;
    wr_ack_nxt    = 1'b0;
    vga_rdata_nxt = vga_rdata;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (wr_req && (!vga_req || starve == SW'(STARVE_LIMIT))) begin
          state_nxt        = WRITE;
          starve_nxt       = '0;
          pins_nxt.ce      = 1'b0;
          pins_nxt.we      = 1'b0;
          pins_nxt.lb      = ~wr_be[0];
          pins_nxt.ub      = ~wr_be[1];
          pins_nxt.adr     = wr_addr;
          pins_nxt.dout    = wr_data;
          pins_nxt.dout_en = 1'b1;
        end else if (vga_req) begin
          state_nxt    = READ;
          starve_nxt   = wr_req ? starve + 1'b1 : '0;
          pins_nxt.ce  = 1'b0;
          pins_nxt.oe  = 1'b0;
          pins_nxt.lb  = 1'b0;
          pins_nxt.ub  = 1'b0;
          pins_nxt.adr = vga_addr;
        end
      end
      READ, WRITE: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(ACCESS_CYCLES - 1)) begin
          state_nxt   = RECOVER;
          cnt_nxt     = '0;
          pins_nxt.ce = 1'b1;
          pins_nxt.oe = 1'b1;
          pins_nxt.we = 1'b1;
          pins_nxt.lb = 1'b1;
          pins_nxt.ub = 1'b1;
          if (state == READ) begin
            vga_rdata_nxt = mem_din;
            vga_ack_nxt   = 1'b1;
          end else begin
            wr_ack_nxt = 1'b1;
          end
        end
      end
      RECOVER: begin
        // write data stays driven through the first recovery cycle for hold time
        cnt_nxt          = cnt + 1'b1;
        pins_nxt.dout_en = 1'b0;
        if (cnt == CW'(RECOVERY_CYCLES - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign MemOE       = pins.oe;
  assign MemWR       = pins.we;
  assign RamCE       = pins.ce;
  assign RamLB       = pins.lb;
  assign RamUB       = pins.ub;
  assign MemAdr      = pins.adr;
  assign mem_dout    = pins.dout;
  assign mem_dout_en = pins.dout_en;
  assign RamADV      = 1'b0;
  assign RamCRE      = 1'b0;
  assign RamClk      = 1'b0;

  a_no_bus_fight: assert property (@(posedge clk) disable iff (!reset_n) !(pins.dout_en && !pins.oe));
endmodule

// File: tb/tb_psdram_arbiter.sv
// Directed then randomized checks of psdram_arbiter against a transaction-schedule model.
module tb_psdram_arbiter;
  localparam int AW = 23, A = 4, R = 1, SL = 8;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          vga_req = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] vga_addr = '0, wr_addr = '0;
  logic [15:0]   wr_data = '0, mem_din = '0;
  logic [1:0]    wr_be = '0;
  logic          vga_ack, wr_ack, MemOE, MemWR, RamCE, RamLB, RamUB, mem_dout_en;
  logic          RamADV, RamCRE, RamClk;
  logic [15:0]   vga_rdata, mem_dout;
  logic [AW-1:0] MemAdr;

  always #10 clk = ~clk;

  psdram_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(A), .RECOVERY_CYCLES(R), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset_n(reset_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
    .MemOE(MemOE), .MemWR(MemWR), .RamCE(RamCE), .RamLB(RamLB), .RamUB(RamUB),
    .MemAdr(MemAdr), .mem_dout(mem_dout), .mem_dout_en(mem_dout_en), .mem_din(mem_din),
    .RamADV(RamADV), .RamCRE(RamCRE), .RamClk(RamClk)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: a grant at cycle g_t occupies the bus until g_t+A+R; next arbitration no earlier than g_t+A+R+1.
  int            cyc = 0, next_arb = 1 << 30, g_t = -100, m_starve = 0;
  bit            active = 0, g_wr = 0, in_rst = 1;
  logic [1:0]    g_be = '0;
  logic [15:0]   g_din = '0, exp_dout = '0, exp_rdata = '0, din_fixed = '0;
  logic [AW-1:0] exp_adr = '0;
  bit            din_fixed_en = 0;
  int            vga_mode = 0, wr_mode = 0;  // 0: drop after ack, 1: re-request at once, 2: random

  task automatic arb();
    if (active && cyc >= next_arb) active = 0;
    if (!in_rst && !active && cyc >= next_arb) begin
      if (wr_req && (!vga_req || m_starve == SL)) begin
        active = 1; g_wr = 1; g_t = cyc; next_arb = cyc + A + R + 1;
        m_starve = 0; exp_adr = wr_addr; exp_dout = wr_data; g_be = wr_be;
      end else if (vga_req) begin
        active = 1; g_wr = 0; g_t = cyc; next_arb = cyc + A + R + 1;
        m_starve = wr_req ? m_starve + 1 : 0; exp_adr = vga_addr;
        mem_din = din_fixed_en ? din_fixed : 16'($urandom);
        g_din = mem_din;
      end
    end
  endtask

  task automatic check_cycle();
    bit acc, first, e_vack, e_wack;
    logic [4:0] e_strb;
    acc    = active && cyc > g_t && cyc <= g_t + A;
    first  = active && cyc == g_t + A + 1;
    e_vack = first && !g_wr;
    e_wack = first && g_wr;
    if (e_vack) exp_rdata = g_din;
    e_strb = {!(acc && !g_wr), !(acc && g_wr), !acc,
              acc ? (g_wr ? ~g_be[0] : 1'b0) : 1'b1,
              acc ? (g_wr ? ~g_be[1] : 1'b0) : 1'b1};
    chk("strobes{OE,WR,CE,LB,UB}", {MemOE, MemWR, RamCE, RamLB, RamUB}, e_strb);
    chk("mem_dout_en", mem_dout_en, (acc || first) && g_wr);
    chk("MemAdr", MemAdr, exp_adr);
    chk("mem_dout", mem_dout, exp_dout);
    chk("acks{vga,wr}", {vga_ack, wr_ack}, {e_vack, e_wack});
    chk("vga_rdata", vga_rdata, exp_rdata);
    if (e_vack) begin
      if (vga_mode == 0) vga_req = 0;
      else begin vga_req = (vga_mode == 1) || ($urandom_range(0, 1) == 1); vga_addr = AW'($urandom); end
    end else if (vga_mode == 2 && !vga_req && $urandom_range(0, 3) == 0) begin
      vga_req = 1; vga_addr = AW'($urandom);
    end
    if (e_wack) wr_req = (wr_mode == 2) && ($urandom_range(0, 1) == 1);
    if (wr_mode == 2 && !wr_req && (e_wack || $urandom_range(0, 5) == 0)) begin
      wr_req = 1; wr_addr = AW'($urandom); wr_data = 16'($urandom); wr_be = 2'($urandom);
    end
  endtask

  task automatic step();
    arb();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  int nv, nw;
  bit got;

  initial begin
    repeat (3) step();
    reset_n = 1; in_rst = 0; next_arb = cyc;

    // idle: nothing may move for 100 cycles
    nv = 0; nw = 0;
    repeat (100) begin step(); nv += int'(vga_ack); nw += int'(wr_ack); end
    chk("idle_acks", nv + nw, 0);

    // single read
    din_fixed_en = 1; din_fixed = 16'hBEEF; vga_addr = 23'h000123; vga_req = 1;
    nv = 0;
    repeat (10) begin step(); nv += int'(vga_ack); end
    chk("read_ack_count", nv, 1);
    chk("read_data", vga_rdata, 16'hBEEF);
    din_fixed_en = 0;

    // single write, lower byte only
    wr_addr = 23'h7FFFFF; wr_data = 16'hA55A; wr_be = 2'b01; wr_req = 1;
    nw = 0;
    repeat (10) begin step(); nw += int'(wr_ack); end
    chk("write_ack_count", nw, 1);

    // simultaneous requests: read first, then write
    vga_addr = 23'h0ABCDE; wr_addr = 23'h012345; wr_data = 16'h1234; wr_be = 2'b10;
    vga_req = 1; wr_req = 1;
    nv = 0; nw = 0;
    repeat (20) begin step(); nv += int'(vga_ack); nw += int'(wr_ack); end
    chk("both_vga_acks", nv, 1);
    chk("both_wr_acks", nw, 1);

    // starvation limit with reads held permanently
    vga_mode = 1; vga_addr = AW'($urandom); vga_req = 1;
    wr_addr = 23'h000777; wr_data = 16'h5555; wr_be = 2'b11; wr_req = 1;
    nv = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (wr_ack) got = 1; else nv += int'(vga_ack);
    end
    chk("starve_write_seen", got, 1);
    chk("starve_reads", nv, SL);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin step(); got = vga_ack; end
    chk("reads_resume", got, 1);
    wr_addr = 23'h000888; wr_data = 16'h6666; wr_be = 2'b00; wr_req = 1;
    nv = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (wr_ack) got = 1; else nv += int'(vga_ack);
    end
    chk("starve2_write_seen", got, 1);
    chk("starve2_reads", nv, SL);
    vga_mode = 0;
    repeat (20) step();

    // reset in the middle of a write
    wr_addr = 23'h300000; wr_data = 16'hC3C3; wr_be = 2'b11; wr_req = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = active && g_wr && cyc == g_t + 2;
    end
    chk("write_started", got, 1);
    reset_n = 0;
    #1;
    chk("rst_MemWR", MemWR, 1);
    chk("rst_RamCE", RamCE, 1);
    chk("rst_dout_en", mem_dout_en, 0);
    active = 0; in_rst = 1; m_starve = 0; next_arb = 1 << 30;
    exp_adr = '0; exp_dout = '0; exp_rdata = '0;
    nw = 0;
    repeat (3) begin step(); nw += int'(wr_ack); end
    chk("rst_no_ack", nw, 0);
    reset_n = 1; in_rst = 0; next_arb = cyc;
    nw = 0;
    repeat (12) begin step(); nw += int'(wr_ack); end
    chk("rst_retry_ack", nw, 1);

    // randomized traffic
    vga_mode = 2; wr_mode = 2;
    repeat (3000) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
